// File: rtl/pri_select_pkg.sv
// Shared definitions for the priority select mux family: index width helper,
// arbitration mode tag and the channel count limit.
package pri_select_pkg;

    localparam int PRI_SELECT_MAX_N = 32;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pri_select_arb.sv
// Combinational find-first-set over a request vector, searching upward from
// a start index and wrapping modulo N.
module pri_select_arb
    import pri_select_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] rotated;
    logic         probe;
    logic [IW:0]  offset;
    logic [IW:0]  pos;

    // Rotate so the start channel sits at bit 0; scanning downward leaves the
    // lowest set offset, i.e. the first requester at or after start.
    always_comb begin
        rotated = N'({req, req} >> start);
        probe   = 1'b0;
        any     = 1'b0;
        offset  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            probe = 1'(rotated >> i);
            if (probe) begin
                any    = 1'b1;
                offset = (IW+1)'(i);
            end
        end
        pos = {1'b0, start} + offset;
        if (pos >= (IW+1)'(N)) begin
            pos = pos - (IW+1)'(N);
        end
        idx    = pos[IW-1:0];
        onehot = any ? (ONE << pos) : '0;
    end

endmodule

// File: rtl/pri_select_mux.sv
// Registered priority select mux with valid/ready output and one-hot grant.
// Define PRI_SELECT_MUX_RR_EN for round-robin arbitration; default is fixed priority.
module pri_select_mux
    import pri_select_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int W  = 11,
    localparam int IW = idx_width(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    output logic [N-1:0]   gnt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [IW-1:0]  out_sel
);

    logic          load;
    logic [IW-1:0] arbStart;
    logic [N-1:0]  arbOnehot;
    logic [IW-1:0] arbIdx;
    logic          arbAny;

    logic          outValid_q, outValid_d;
    logic [W-1:0]  outData_q, outData_d;
    logic [IW-1:0] outSel_q, outSel_d;

    pri_select_arb #(
        .N  (N),
        .IW (IW)
    ) u_arb (
        .req    (req),
        .start  (arbStart),
        .onehot (arbOnehot),
        .idx    (arbIdx),
        .any    (arbAny)
    );

    assign load = !outValid_q || out_ready;

    // Grant is masked while in reset: out_valid is already low then, so load
    // alone would let requests through.
    assign gnt = (load && arbAny && reset_n) ? arbOnehot : '0;

    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSel_d   = outSel_q;
        if (load) begin
            outValid_d = arbAny;
            if (arbAny) begin
                outData_d = W'(data_in >> (arbIdx * W));
                outSel_d  = arbIdx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSel_q   <= '0;
        end else begin
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSel_q   <= outSel_d;
        end
    end

`ifdef PRI_SELECT_MUX_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;

    // Pointer moves one past the winner on every grant, wrapping N-1 to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (load && arbAny) begin
            ptr_d = (arbIdx == IW'(N - 1)) ? '0 : arbIdx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign arbStart = ptr_q;
`else
    assign arbStart = '0;
`endif

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_sel   = outSel_q;

endmodule

// File: doc/pri_select_mux.md
# pri_select_mux

Parametrised, registered successor to the hand-written select-chain muxes in our datapath modules. Selects one of N W-bit input channels by request priority, registers the winner behind a valid/ready output handshake, and returns a one-hot grant to the winning source. Arbitration is fixed-priority or, when compiled in, round-robin. The block sits between request-driven sources and a single downstream consumer.

## Interface
- N, 8, number of input channels; legal range 2..32.
- W, 11, data width per channel; must be 1 or greater.
- IW, $clog2(N), index width; derived, not overridden.
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  N  per-channel request; req[i] means data_in slice i is valid.
- data_in  input  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- gnt  output  N  one-hot grant; high in the cycle channel i is accepted. Combinational from req, state and out_ready.
- out_valid  output  1  registered data valid.
- out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high.
- out_data  output  W  registered selected data.
- out_sel  output  IW  registered index of the channel held in out_data.

## Operation
- The load enable is `load = !out_valid || out_ready`.
- Arbitration when `load` is high:
  - Fixed mode: the lowest-index asserted req wins (req[0] highest priority).
  - RR mode: the search starts at pointer `ptr` and wraps modulo N; the first asserted req wins.
- On load with any req asserted:
  - gnt asserts for the winner.
  - Next cycle: out_data = winner data, out_sel = winner index, out_valid = 1.
- On load with no req asserted: gnt = 0 and out_valid goes to 0 next cycle. out_data and out_sel hold their previous values.
- Stall (out_valid && !out_ready):
  - gnt = 0.
  - out_data, out_sel and out_valid hold.
  - ptr holds.
  - A request stays pending; the source must keep req and data stable until it receives gnt.
- RR pointer update: on a grant to channel i, ptr becomes (i+1) mod N, so channel N-1 wraps to 0. There is no update on cycles without a grant.
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0. gnt=0 while reset_n is low.
- Reset asserted mid-transfer clears out_valid immediately (asynchronously). Held data is discarded with no handshake completion.

## Timing
- Latency is 1 cycle from gnt to out_valid.
- Throughput is 1 transfer per cycle when out_ready is held high.
- When out_valid, out_ready and a req are all high in the same cycle, the current item retires and the new winner loads on the same edge. There is no bubble.
- gnt depends combinationally on out_ready. out_ready must not depend combinationally on gnt.
- The first load occurs on the first rising edge after reset_n deasserts.

## Configuration
- Macro: PRI_SELECT_MUX_RR_EN.
- When defined: round-robin arbitration with the ptr register, as described above.
- When undefined: fixed priority only. ptr and its update logic are absent, and the search always starts at 0.
- Ports and handshake are identical in both builds.

## Structure
- Shared package `pri_select_pkg` contains:
  - The `idx_width(n)` function.
  - The `arb_mode_e` enum (ARB_FIXED, ARB_RR), used for reporting the compiled mode.
  - A localparam for the maximum N (32).
- Sub-module `pri_select_arb` is a combinational find-first-set from a start index with wrap.
  - Inputs: req, start.
  - Outputs: onehot, idx, any.
  - It is instantiated once. start is tied to 0 in fixed mode.
- The top level holds the handshake, the output registers and ptr.

## Test plan
- Reset/idle:
  - Stimulus: hold reset_n=0 with req=8'hFF, then release with req=0.
  - Required response: out_valid=0, out_data=0, out_sel=0 and gnt=0 throughout.
- Fixed priority (macro undefined, N=8, W=11):
  - Stimulus: req=8'b1010_0100, out_ready=1.
  - Required response: gnt=8'b0000_0100, then out_sel=2 and out_data=channel 2 data.
  - Stimulus: drop req[2].
  - Required response: gnt=8'b0010_0000, out_sel=5.
- Round-robin (macro defined):
  - Stimulus: req=8'hFF held, out_ready=1.
  - Required response: out_sel runs 0,1,…,7,0 on consecutive cycles, with no bubbles.
- Wrap with gaps (macro defined):
  - Stimulus: ptr=6, req=8'b0000_1001.
  - Required response: channel 0 granted, then channel 3.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with out_valid=1.
  - Required response: out_data and out_sel stable, gnt=0, ptr unchanged.
  - Stimulus: raise out_ready with a req pending.
  - Required response: the pending winner loads on that edge.
- Async reset mid-stall:
  - Stimulus: pulse reset_n low between clock edges while out_valid=1.
  - Required response: out_valid falls immediately, ptr=0, and the next grant is to the lowest-index requester.
